// File: rtl/int_sequencer_if.sv
// Handshake bundle between the interrupt sequencer and the 6502 core control path.
interface int_sequencer_if;
  logic        nmi;
  logic        irq;
  logic        iflag;
  logic        sync;
  logic        seq_done;
  logic        int_req;
  logic        in_service;
  logic        rst_busy;
  logic [15:0] vec_addr;
  logic        b_flag;
  logic        nmi_ack;

  modport master (
    output nmi, irq, iflag, sync, seq_done,
    input  int_req, in_service, rst_busy, vec_addr, b_flag, nmi_ack
  );

  modport slave (
    input  nmi, irq, iflag, sync, seq_done,
    output int_req, in_service, rst_busy, vec_addr, b_flag, nmi_ack
  );
endinterface

// File: rtl/int_sequencer.sv
// 6502 interrupt/reset sequencer: reset stall, NMI edge capture, IRQ qualification
// and interrupt entry arbitration at opcode-fetch boundaries.
module int_sequencer #(
  parameter int unsigned RST_CYCLES = 7,
  parameter logic [15:0] NMI_VEC    = 16'hFFFA,
  parameter logic [15:0] RST_VEC    = 16'hFFFC,
  parameter logic [15:0] IRQ_VEC    = 16'hFFFE
) (
  input  logic             clk,
  input  logic             rst,
  int_sequencer_if.slave   io_bus
);

  localparam int unsigned     CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RST_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RESET   = 2'd0,
    ST_IDLE    = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  typedef enum logic {
    KIND_IRQ = 1'b0,
    KIND_NMI = 1'b1
  } kind_t;

  state_t           r_state, w_state_nxt;
  kind_t            r_kind, w_kind_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_nmi_q;
  logic             r_nmi_pend, w_nmi_pend_nxt;
  logic             r_irq_q;
  logic             r_nmi_ack, w_nmi_ack_nxt;
  logic             w_nmi_edge;
  logic             w_int_req;
  logic             w_accept;

  // State and sampled-input registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_RESET;
      r_kind     <= KIND_IRQ;
      r_cnt      <= '0;
      r_nmi_q    <= 1'b0;
      r_nmi_pend <= 1'b0;
      r_irq_q    <= 1'b0;
      r_nmi_ack  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_kind     <= w_kind_nxt;
      r_cnt      <= w_cnt_nxt;
      r_nmi_q    <= io_bus.nmi;
      r_nmi_pend <= w_nmi_pend_nxt;
      r_irq_q    <= io_bus.irq & ~io_bus.iflag;
      r_nmi_ack  <= w_nmi_ack_nxt;
    end
  end

  // Next state, stall count, NMI latch and acceptance
  always_comb begin
    w_state_nxt    = r_state;
    w_kind_nxt     = r_kind;
    w_cnt_nxt      = r_cnt;
    w_nmi_pend_nxt = r_nmi_pend;
    w_nmi_ack_nxt  = 1'b0;
    w_int_req      = 1'b0;
    w_accept       = 1'b0;
    w_nmi_edge     = io_bus.nmi & ~r_nmi_q;

    case (r_state)
      ST_RESET: begin
        w_nmi_pend_nxt = 1'b0;
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_IDLE: begin
        w_int_req = r_nmi_pend | r_irq_q;
        w_accept  = w_int_req & io_bus.sync;
        // An edge arriving in the acceptance cycle is a fresh request and survives the clear
        w_nmi_pend_nxt = w_nmi_edge | (r_nmi_pend & ~w_accept);
        if (w_accept) begin
          w_state_nxt   = ST_SERVICE;
          w_kind_nxt    = r_nmi_pend ? KIND_NMI : KIND_IRQ;
          w_nmi_ack_nxt = r_nmi_pend;
        end
      end
      ST_SERVICE: begin
        w_nmi_pend_nxt = r_nmi_pend | w_nmi_edge;
        if (io_bus.seq_done) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_RESET;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    io_bus.int_req    = w_int_req;
    io_bus.in_service = (r_state == ST_SERVICE);
    io_bus.rst_busy   = (r_state == ST_RESET);
    io_bus.b_flag     = (r_state != ST_SERVICE);
    io_bus.nmi_ack    = r_nmi_ack;
    io_bus.vec_addr   = IRQ_VEC;
    if (r_state == ST_RESET) begin
      io_bus.vec_addr = RST_VEC;
    end else if ((r_state == ST_SERVICE) && (r_kind == KIND_NMI)) begin
      io_bus.vec_addr = NMI_VEC;
    end
  end

endmodule

// File: tb/tb_int_sequencer.sv
// Directed bench for int_sequencer: per-cycle comparison against a behavioural
// model plus literal checks at the key points of each scenario.
module tb_int_sequencer;

  localparam int unsigned RST_CYCLES = 7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int_sequencer_if bus ();

  int_sequencer #(
    .RST_CYCLES (RST_CYCLES),
    .NMI_VEC    (16'hFFFA),
    .RST_VEC    (16'hFFFC),
    .IRQ_VEC    (16'hFFFE)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: countdown stall, pending NMI flag, serving flag
  bit m_in_reset, m_pend, m_irq_ok, m_nmi_prev, m_serving, m_serve_nmi, m_ack;
  bit m_edge, m_req, m_acc;
  int m_stall;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_in_reset = 1'b1; m_stall = RST_CYCLES; m_pend = 1'b0; m_irq_ok = 1'b0;
      m_nmi_prev = 1'b0; m_serving = 1'b0; m_serve_nmi = 1'b0; m_ack = 1'b0;
    end else begin
      if (m_in_reset) begin
        m_stall = m_stall - 1;
        if (m_stall == 0) m_in_reset = 1'b0;
        m_pend = 1'b0;
        m_ack  = 1'b0;
      end else begin
        m_edge = bus.nmi && !m_nmi_prev;
        m_req  = !m_serving && (m_pend || m_irq_ok);
        m_acc  = m_req && bus.sync;
        m_ack  = m_acc && m_pend;
        if (m_serving) begin
          if (bus.seq_done) m_serving = 1'b0;
        end else if (m_acc) begin
          m_serving   = 1'b1;
          m_serve_nmi = m_pend;
        end
        m_pend = m_edge || (m_pend && !m_ack);
      end
      m_irq_ok   = bus.irq && !bus.iflag;
      m_nmi_prev = bus.nmi;
    end
  end

  // Compare every cycle on the falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_int_req",    32'(bus.int_req),    32'(!m_in_reset && !m_serving && (m_pend || m_irq_ok)));
      chk("m_in_service", 32'(bus.in_service), 32'(m_serving));
      chk("m_rst_busy",   32'(bus.rst_busy),   32'(m_in_reset));
      chk("m_b_flag",     32'(bus.b_flag),     32'(!m_serving));
      chk("m_nmi_ack",    32'(bus.nmi_ack),    32'(m_ack));
      chk("m_vec_addr",   32'(bus.vec_addr),
          m_in_reset ? 32'hFFFC : (m_serving && m_serve_nmi) ? 32'hFFFA : 32'hFFFE);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int busy_n, ack_n, entry_n;
  bit prev_svc;

  initial begin
    rst = 1'b1;
    bus.nmi = 1'b0; bus.irq = 1'b0; bus.iflag = 1'b0; bus.sync = 1'b0; bus.seq_done = 1'b0;
    cyc(); cyc();
    chk_en = 1'b1;
    cyc();
    chk("rst_busy_in_reset", 32'(bus.rst_busy), 32'd1);
    chk("vec_in_reset",      32'(bus.vec_addr), 32'hFFFC);
    chk("b_flag_in_reset",   32'(bus.b_flag),   32'd1);
    chk("int_req_in_reset",  32'(bus.int_req),  32'd0);

    // Reset stall length
    rst = 1'b0;
    busy_n = 0;
    for (int i = 0; i < 20 && bus.rst_busy; i++) begin
      cyc();
      busy_n++;
    end
    chk("rst_stall_len", 32'(busy_n), 32'd7);
    chk("idle_vec", 32'(bus.vec_addr), 32'hFFFE);
    chk("idle_int_req", 32'(bus.int_req), 32'd0);

    // Plain IRQ sequence
    bus.irq = 1'b1; cyc();
    chk("irq_int_req", 32'(bus.int_req), 32'd1);
    cyc();
    bus.sync = 1'b1; cyc();
    chk("irq_in_service", 32'(bus.in_service), 32'd1);
    chk("irq_vec", 32'(bus.vec_addr), 32'hFFFE);
    chk("irq_b_flag", 32'(bus.b_flag), 32'd0);
    bus.sync = 1'b0; bus.irq = 1'b0; cyc(); cyc();
    bus.seq_done = 1'b1; cyc();
    chk("irq_done_svc", 32'(bus.in_service), 32'd0);
    chk("irq_done_b", 32'(bus.b_flag), 32'd1);
    bus.seq_done = 1'b0; cyc();

    // Masked IRQ never requests
    bus.iflag = 1'b1; bus.irq = 1'b1; bus.sync = 1'b1;
    repeat (3) cyc();
    chk("masked_int_req", 32'(bus.int_req), 32'd0);
    chk("masked_svc", 32'(bus.in_service), 32'd0);
    bus.irq = 1'b0; bus.iflag = 1'b0; bus.sync = 1'b0; cyc();

    // NMI beats IRQ, then IRQ follows
    bus.nmi = 1'b1; bus.irq = 1'b1; cyc();
    chk("both_int_req", 32'(bus.int_req), 32'd1);
    bus.sync = 1'b1; cyc();
    chk("nmi_vec", 32'(bus.vec_addr), 32'hFFFA);
    chk("nmi_ack_pulse", 32'(bus.nmi_ack), 32'd1);
    bus.sync = 1'b0; bus.nmi = 1'b0; cyc();
    chk("nmi_ack_one_clk", 32'(bus.nmi_ack), 32'd0);
    bus.seq_done = 1'b1; cyc();
    bus.seq_done = 1'b0;
    chk("irq_after_nmi_req", 32'(bus.int_req), 32'd1);
    bus.sync = 1'b1; cyc();
    chk("irq_after_nmi_vec", 32'(bus.vec_addr), 32'hFFFE);
    bus.sync = 1'b0; bus.irq = 1'b0; cyc();
    bus.seq_done = 1'b1; cyc();
    bus.seq_done = 1'b0; cyc();

    // Held-high NMI across two sequences: one NMI acceptance
    ack_n = 0; entry_n = 0; prev_svc = 1'b0;
    for (int i = 0; i < 12; i++) begin
      bus.nmi = 1'b1; bus.sync = 1'b1;
      bus.irq = (i < 6);
      bus.seq_done = (i == 3) || (i == 7);
      cyc();
      if (bus.nmi_ack) ack_n++;
      if (bus.in_service && !prev_svc) entry_n++;
      prev_svc = bus.in_service;
    end
    chk("held_nmi_acks", 32'(ack_n), 32'd1);
    chk("held_nmi_entries", 32'(entry_n), 32'd2);
    bus.nmi = 1'b0; bus.sync = 1'b0; bus.irq = 1'b0; bus.seq_done = 1'b0; cyc();

    // NMI pulse during SERVICE is served after seq_done
    bus.irq = 1'b1; cyc();
    bus.sync = 1'b1; cyc();
    bus.sync = 1'b0; bus.irq = 1'b0; bus.nmi = 1'b1; cyc();
    bus.nmi = 1'b0; cyc();
    chk("svc_nmi_no_req", 32'(bus.int_req), 32'd0);
    bus.seq_done = 1'b1; cyc();
    bus.seq_done = 1'b0;
    chk("svc_nmi_req_after", 32'(bus.int_req), 32'd1);
    cyc();
    bus.sync = 1'b1; cyc();
    chk("svc_nmi_vec", 32'(bus.vec_addr), 32'hFFFA);
    chk("svc_nmi_ack", 32'(bus.nmi_ack), 32'd1);
    bus.sync = 1'b0; bus.seq_done = 1'b1; cyc();
    bus.seq_done = 1'b0; cyc();

    // Reset mid-SERVICE with NMI pending discards the NMI
    bus.irq = 1'b1; cyc();
    bus.sync = 1'b1; cyc();
    bus.sync = 1'b0; bus.irq = 1'b0; bus.nmi = 1'b1; cyc();
    bus.nmi = 1'b0; cyc();
    rst = 1'b1; #1;
    chk("midrst_busy", 32'(bus.rst_busy), 32'd1);
    chk("midrst_svc", 32'(bus.in_service), 32'd0);
    chk("midrst_vec", 32'(bus.vec_addr), 32'hFFFC);
    chk("midrst_b", 32'(bus.b_flag), 32'd1);
    cyc(); cyc();
    rst = 1'b0;
    repeat (RST_CYCLES) cyc();
    chk("midrst_stall_end", 32'(bus.rst_busy), 32'd0);
    bus.sync = 1'b1;
    repeat (4) begin
      cyc();
      chk("midrst_no_nmi_req", 32'(bus.int_req), 32'd0);
      chk("midrst_no_nmi_svc", 32'(bus.in_service), 32'd0);
    end
    bus.sync = 1'b0; cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
